alu_rr_arbiter: RTL and testbench

//  Shares one ALU #(N) instance between two requesters (req0, req1) using round-robin arbitration.

---
 rtl/alu_rr_arbiter_pkg.sv | 16 +
 rtl/alu_rr_arbiter_if.sv | 17 +
 rtl/alu_rr_arbiter_alu.sv | 54 +++++
 rtl/alu_rr_arbiter.sv | 70 +++++++
 tb/tb_alu_rr_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// alu_rr_arbiter_pkg: FSM states, ALU op encodings and flag bit positions shared by the arbiter slice
package alu_rr_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: two request channels and one tagged response channel around the shared ALU
interface alu_rr_arbiter_if #(parameter int N = 3);
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_rr_arbiter_alu.sv
// alu_rr_arbiter_alu: combinational N-bit ALU producing result and {N,Z,C,V} flags
module alu_rr_arbiter_alu
    import alu_rr_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    logic [N:0] wide;
    logic       c, v;
    // C is carry-out for ADD, borrow for SUB, and the shifted-out bit for shifts
    always_comb begin
        wide   = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[N-1:0];
                c      = wide[N];
                v      = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[N-1:0];
                c      = wide[N];
                v      = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = a << 1;
                c      = a[N-1];
            end
            OP_SHR: begin
                result = a >> 1;
                c      = a[0];
            end
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[N-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one ALU between two requesters with a held, id-tagged response
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input logic            clk,
    input logic            rst,
    alu_rr_arbiter_if.slave bus
);
    state_t       state, next_state;
    logic         last_grant, grant_id, any_valid, accept;
    logic         op_id;
    logic [N-1:0] op_a, op_b, alu_result;
    logic [3:0]   op_op, alu_flags;

    alu_rr_arbiter_alu #(.N(N)) u_alu (
        .a(op_a),
        .b(op_b),
        .op(op_op),
        .result(alu_result),
        .flags(alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // ready is gated by rst so nothing is offered while reset is asserted
    always_comb begin
        any_valid      = bus.req0_valid | bus.req1_valid;
        grant_id       = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept         = !rst && (state == IDLE) && any_valid;
        next_state     = (state == IDLE) ? (any_valid ? EXEC : IDLE) :
                         (state == EXEC) ? HOLD :
                         (bus.rsp_ready ? IDLE : HOLD);
        bus.req0_ready = accept & ~grant_id;
        bus.req1_ready = accept & grant_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= 1'b1;
            op_id          <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_op          <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
        end else begin
            if (accept) begin
                op_id      <= grant_id;
                op_a       <= grant_id ? bus.req1_a  : bus.req0_a;
                op_b       <= grant_id ? bus.req1_b  : bus.req0_b;
                op_op      <= grant_id ? bus.req1_op : bus.req0_op;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                bus.rsp_result <= alu_result;
                bus.rsp_flags  <= alu_flags;
                bus.rsp_id     <= op_id;
                bus.rsp_valid  <= 1'b1;
            end
            if (state == HOLD && bus.rsp_valid && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed vectors with hand-computed results for the round-robin ALU arbiter
module tb_alu_rr_arbiter;
    import alu_rr_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_rr_arbiter_if #(.N(3)) bus ();
    alu_rr_arbiter #(.N(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
        if (id == 1) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    // presents a request, waits for its ready, then checks the latency and the response contents
    task automatic do_op(input string tag, input int id, input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] op, input logic [2:0] exp_res, input logic [3:0] exp_flags);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        set_req(id, 1'b1, a, b, op);
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            seen = (id == 1) ? bus.req1_ready : bus.req0_ready;
            if (!seen) @(negedge clk);
        end
        check({tag, "_ready"}, seen, 1'b1);
        @(posedge clk);
        #1 set_req(id, 1'b0, 3'd0, 3'd0, 4'd0);
        @(negedge clk);
        check({tag, "_lat_exec"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_id"}, bus.rsp_id, id[0]);
        check({tag, "_result"}, bus.rsp_result, exp_res);
        check({tag, "_flags"}, bus.rsp_flags, exp_flags);
    endtask

    initial begin
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b0, 3'd0, 3'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 3'd0, 4'd0);
        #12;
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_result", bus.rsp_result, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_zero", 0, 3'b000, 3'b000, OP_ADD, 3'b000, 4'b0100);
        do_op("add_wrap", 1, 3'b011, 3'b101, OP_ADD, 3'b000, 4'b0110);
        do_op("add_ovf", 0, 3'b011, 3'b001, OP_ADD, 3'b100, 4'b1001);
        do_op("sub_borrow", 1, 3'b000, 3'b001, OP_SUB, 3'b111, 4'b1010);

        // both valid: req0 3+... after last grant to req1, pulses 0,1,0,1,0 every 3 cycles
        @(negedge clk);
        set_req(0, 1'b1, 3'b001, 3'b010, OP_ADD);
        set_req(1, 1'b1, 3'b010, 3'b010, OP_SUB);
        for (int i = 0; i < 13; i++) begin
            #1;
            check($sformatf("rr_r0_c%0d", i), bus.req0_ready, (i % 3 == 0) && ((i / 3) % 2 == 0));
            check($sformatf("rr_r1_c%0d", i), bus.req1_ready, (i % 3 == 0) && ((i / 3) % 2 == 1));
            if (i % 3 == 2) begin
                check($sformatf("rr_valid_c%0d", i), bus.rsp_valid, 1'b1);
                check($sformatf("rr_id_c%0d", i), bus.rsp_id, (i / 3) % 2);
                check($sformatf("rr_res_c%0d", i), bus.rsp_result, ((i / 3) % 2) ? 3'b000 : 3'b011);
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, 3'd0, 3'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 3'd0, 4'd0);
        repeat (3) @(negedge clk);

        // held response under backpressure, with a competing request that must not be granted
        bus.rsp_ready = 1'b0;
        do_op("and_hold", 0, 3'b110, 3'b011, OP_AND, 3'b010, 4'b0000);
        set_req(1, 1'b1, 3'b111, 3'b111, OP_OR);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_valid_%0d", i), bus.rsp_valid, 1'b1);
            check($sformatf("hold_result_%0d", i), bus.rsp_result, 3'b010);
            check($sformatf("hold_id_%0d", i), bus.rsp_id, 1'b0);
            check($sformatf("hold_rdy_%0d", i), {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        set_req(1, 1'b0, 3'd0, 3'd0, 4'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", bus.rsp_valid, 1'b0);
        check("drain_result_kept", bus.rsp_result, 3'b010);

        // mid-test reset with both valid: everything low; first tie afterwards goes to req0
        @(negedge clk);
        set_req(0, 1'b1, 3'b101, 3'b011, OP_XOR);
        set_req(1, 1'b1, 3'b001, 3'b001, OP_ADD);
        rst = 1'b1;
        #1;
        check("mrst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("mrst_valid", bus.rsp_valid, 1'b0);
        check("mrst_result", bus.rsp_result, 3'd0);
        check("mrst_flags", bus.rsp_flags, 4'd0);
        check("mrst_id", bus.rsp_id, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("tie_after_rst", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 3'd0, 3'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 3'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("xor_valid", bus.rsp_valid, 1'b1);
        check("xor_result", bus.rsp_result, 3'b110);
        check("xor_flags", bus.rsp_flags, 4'b1000);

        // reset while the op is executing: its response must never appear
        @(negedge clk);
        set_req(1, 1'b1, 3'b010, 3'b011, OP_SUB);
        #1;
        check("exec_rst_ready", bus.req1_ready, 1'b1);
        @(posedge clk);
        #1 set_req(1, 1'b0, 3'd0, 3'd0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("exec_rst_valid_%0d", i), bus.rsp_valid, 1'b0);
        end
        do_op("post_rst_add", 0, 3'b001, 3'b001, OP_ADD, 3'b010, 4'b0000);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
